ham_decode_125: RTL and testbench
=================================

// Module: ham_decode_125
// PURPOSE
//  Receive-side counterpart of the Hamming(17,12) encoder. It accepts 17-bit codewords on a
//  valid/ready stream, computes the 5-bit syndrome and corrects any single-bit error.
//  It returns the 12 data bits plus per-word error flags, with a 2-stage pipeline and full backpressure.
//  Two saturating counters track corrected and uncorrectable words for status readout.
// PARAMETERS
//  CNT_W    16   width of the corrected/uncorrectable event counters (saturating)
// PORTS
//  clk           in   1      single clock, all state on rising edge
//  resetn        in   1      asynchronous active-low reset
//  in_valid      in   1      in_code is valid this cycle
//  in_ready      out  1      decoder can accept in_code this cycle
//  in_code       in   17     codeword; bit p-1 holds Hamming position p (p=1..17)
//  out_valid     out  1      out_data/flags valid
//  out_ready     in   1      sink accepts output this cycle
//  out_data      out  12     decoded (corrected) data
//  out_corrected out  1      word had a nonzero syndrome 1..17, one bit flipped back
//  out_uncorr    out  1      syndrome 18..31: no correction applied, data passed raw
//  out_syndrome  out  5      syndrome of this word
//  cnt_clear     in   1      synchronous clear of both counters
//  cnt_corr      out  CNT_W  number of accepted outputs with out_corrected=1
//  cnt_uncorr    out  CNT_W  number of accepted outputs with out_uncorr=1
// BEHAVIOUR
//  - Code layout: parity at positions 1,2,4,8,16 (bits 0,1,3,7,15). Data d[0..11] at positions
//    3,5,6,7,9,10,11,12,13,14,15,17 in ascending order.
//  - Syndrome bit k = XOR of in_code bits whose position has bit k set (k=0..4).
//    This makes the syndrome equal to the XOR of the positions of all set bits.
//  - Stage 1 (S1) registers the code and syndrome. Stage 2 (S2, the output register) applies the flip:
//    position = syndrome if 1..17; data is then extracted from the flipped word.
//  - syndrome 0: corrected=0, uncorr=0. Syndrome 1..17: corrected=1, even when the flipped bit is parity.
//    Syndrome 18..31: uncorr=1, no flip. Double errors whose syndrome is <=17 are miscorrected;
//    this is an accepted SEC-only limitation.
//  - Handshake: input beat accepted when in_valid&&in_ready; output beat consumed when
//    out_valid&&out_ready. Producer must hold in_code stable while in_valid&&!in_ready.
//  - s2_load = !out_valid || out_ready; s1_move = s1_valid && s2_load; in_ready = !s1_valid || s2_load.
//    in_ready is combinational from out_ready and state; there is no path from in_valid.
//  - out_valid is set when S2 loads from a valid S1. It is cleared when consumed with no S1 word moving in.
//  - Latency: 2 cycles accept->out_valid with no stall. Sustains 1 word/cycle while out_ready=1.
//    While stalled, out_* are held stable, up to 2 words are held, and in_ready=0 once S1 is full.
//  - Counters: +1 on each consumed output beat that carries the matching flag. They saturate at
//    2^CNT_W-1 and never wrap. cnt_clear zeroes both counters and wins over a same-cycle increment.
//  - Reset (async, any time including mid-transfer): out_valid=0, S1 valid=0, out_data=0,
//    out_corrected=0, out_uncorr=0, out_syndrome=0, counters=0. in_ready=1 while held in reset.
//    In-flight words are dropped.
// TESTING
//  1 in_code=17'h00000 -> 2 cycles later out_data=12'h000, syndrome=0, corrected=0, uncorr=0
//  2 in_code=17'h00010 (pos 5 flipped) -> out_data=12'h000, syndrome=5, corrected=1, cnt_corr=1
//  3 in_code=17'h1FFFF -> syndrome=1, parity bit fixed, out_data=12'hFFF, corrected=1
//  4 in_code=17'h08002 (pos 16+2) -> syndrome=18, uncorr=1, out_data=12'h000, cnt_uncorr=1
//  5 stream 8 words with out_ready toggling 1010..; at in_valid=1,out_ready=0 for 3 cycles
//    -> in_ready=0 once 2 words are held, order preserved, no loss/duplication
//  6 assert resetn=0 with 2 words in flight -> out_valid=0 async, counters=0; cnt_clear on an
//    incrementing beat -> counter reads 0 next cycle; preload 16'hFFFF -> saturates

Source files
------------

// File: rtl/ham_decode_125_if.sv
// Stream bundle for the Hamming(17,12) decoder: codeword input side and decoded-word output side.
`timescale 1ns/1ps
interface ham_decode_125_if;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] in_code;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic        out_corrected;
    logic        out_uncorr;
    logic [4:0]  out_syndrome;

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_data, out_corrected, out_uncorr, out_syndrome
    );

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_data, out_corrected, out_uncorr, out_syndrome
    );
endinterface

// File: rtl/ham_decode_125.sv
// Hamming(17,12) SEC decoder: syndrome in stage 1, single-bit correction and data extraction in
// stage 2, with full valid/ready backpressure and saturating corrected/uncorrectable counters.
`timescale 1ns/1ps
module ham_decode_125 #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             resetn,
    ham_decode_125_if.slave  bus,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] cnt_corr,
    output logic [CNT_W-1:0] cnt_uncorr
);

    function automatic logic [4:0] syndrome_of(input logic [16:0] code);
        logic [4:0] s;
        s = '0;
        for (int p = 1; p <= 17; p++) begin
            if (code[p-1]) s = s ^ 5'(p);
        end
        return s;
    endfunction

    function automatic logic [16:0] apply_flip(input logic [16:0] code, input logic [4:0] syn);
        if (syn != 5'd0 && syn <= 5'd17) return code ^ (17'd1 << (syn - 5'd1));
        return code;
    endfunction

    // Data positions 3,5,6,7,9..15,17 map to code bits 2,4..6,8..14,16.
    function automatic logic [11:0] extract_data(input logic [16:0] c);
        return {c[16], c[14:8], c[6:4], c[2]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [16:0] code_p1;
    logic [4:0]  syn_p1;
    logic        vld_p1;
    logic        vld_p2;
    logic [11:0] data_p2;
    logic        corr_p2;
    logic        uncorr_p2;
    logic [4:0]  syn_p2;
    logic        s2_load;
    logic        s1_move;
    logic        accept;
    logic        consume;

    assign s2_load      = !vld_p2 || bus.out_ready;
    assign s1_move      = vld_p1 && s2_load;
    assign bus.in_ready = !vld_p1 || s2_load;
    assign accept       = bus.in_valid && bus.in_ready;
    assign consume      = vld_p2 && bus.out_ready;

    // ---- stage 1: register codeword and its syndrome ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
        end else if (s1_move) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            code_p1 <= bus.in_code;
            syn_p1  <= syndrome_of(bus.in_code);
        end
    end

    // ---- stage 2: correct, extract data, classify (output register) ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_p2    <= 1'b0;
            data_p2   <= '0;
            corr_p2   <= 1'b0;
            uncorr_p2 <= 1'b0;
            syn_p2    <= '0;
        end else begin
            if (s2_load) vld_p2 <= vld_p1;
            if (s1_move) begin
                data_p2   <= extract_data(apply_flip(code_p1, syn_p1));
                corr_p2   <= (syn_p1 != 5'd0) && (syn_p1 <= 5'd17);
                uncorr_p2 <= (syn_p1 >= 5'd18);
                syn_p2    <= syn_p1;
            end
        end
    end

    // Counters advance on consumed beats only; clear takes priority.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (cnt_clear) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (consume) begin
            if (corr_p2)   cnt_corr   <= sat_inc(cnt_corr);
            if (uncorr_p2) cnt_uncorr <= sat_inc(cnt_uncorr);
        end
    end

    assign bus.out_valid     = vld_p2;
    assign bus.out_data      = data_p2;
    assign bus.out_corrected = corr_p2;
    assign bus.out_uncorr    = uncorr_p2;
    assign bus.out_syndrome  = syn_p2;

endmodule

// File: tb/tb_ham_decode_125.sv
// Self-checking bench for ham_decode_125: behavioural decode model + scoreboard checked every cycle,
// with directed vectors for the listed cases, backpressure, async reset, clear and saturation.
`timescale 1ns/1ps
module tb_ham_decode_125;

    localparam int DPOS [12] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17};

    typedef struct {
        logic [11:0] data;
        logic        corr;
        logic        uncorr;
        logic [4:0]  syn;
        int          tag;
    } ent_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cnt_clear;
    logic [15:0] cnt_corr;
    logic [15:0] cnt_uncorr;

    ham_decode_125_if bus();

    ham_decode_125 #(.CNT_W(16)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .cnt_clear (cnt_clear),
        .cnt_corr  (cnt_corr),
        .cnt_uncorr(cnt_uncorr)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          pops = 0;
    ent_t        q[$];
    logic [15:0] m_corr = '0;
    logic [15:0] m_uncorr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic ent_t model(input logic [16:0] code);
        ent_t        e;
        logic [16:0] c;
        logic [4:0]  s;
        c = code;
        s = '0;
        for (int k = 0; k < 5; k++)
            for (int p = 1; p <= 17; p++)
                if (((p >> k) & 1) != 0) s[k] = s[k] ^ c[p-1];
        e.syn    = s;
        e.corr   = (s >= 5'd1) && (s <= 5'd17);
        e.uncorr = (s >= 5'd18);
        if (e.corr) c[s-5'd1] = ~c[s-5'd1];
        for (int i = 0; i < 12; i++) e.data[i] = c[DPOS[i]-1];
        e.tag = 0;
        return e;
    endfunction

    function automatic logic [16:0] enc(input logic [11:0] d, input int flip);
        logic [16:0] c;
        logic [4:0]  s;
        c = '0;
        s = '0;
        for (int i = 0; i < 12; i++) c[DPOS[i]-1] = d[i];
        for (int p = 1; p <= 17; p++) if (c[p-1]) s = s ^ 5'(p);
        for (int k = 0; k < 5; k++) if (s[k]) c[(1 << k) - 1] = 1'b1;
        if (flip > 0) c[flip-1] = ~c[flip-1];
        return c;
    endfunction

    // Scoreboard compare: outputs sampled on the falling edge, model advanced for the next rising edge.
    always @(negedge clk) begin
        if (!resetn) begin
            chk("rst_out_valid", 32'(bus.out_valid), 0);
            chk("rst_out_data", 32'(bus.out_data), 0);
            chk("rst_flags", {30'd0, bus.out_corrected, bus.out_uncorr}, 0);
            chk("rst_syndrome", 32'(bus.out_syndrome), 0);
            chk("rst_in_ready", 32'(bus.in_ready), 1);
            chk("rst_cnt_corr", 32'(cnt_corr), 0);
            chk("rst_cnt_uncorr", 32'(cnt_uncorr), 0);
            q.delete();
            m_corr   = '0;
            m_uncorr = '0;
        end else begin
            chk("in_ready", 32'(bus.in_ready), 32'((q.size() < 2) || bus.out_ready));
            chk("out_valid", 32'(bus.out_valid), 32'((q.size() > 0) && (cyc - q[0].tag >= 2)));
            if (bus.out_valid && q.size() > 0) begin
                chk("out_data", 32'(bus.out_data), 32'(q[0].data));
                chk("out_syndrome", 32'(bus.out_syndrome), 32'(q[0].syn));
                chk("out_corrected", 32'(bus.out_corrected), 32'(q[0].corr));
                chk("out_uncorr", 32'(bus.out_uncorr), 32'(q[0].uncorr));
            end
            chk("cnt_corr", 32'(cnt_corr), 32'(m_corr));
            chk("cnt_uncorr", 32'(cnt_uncorr), 32'(m_uncorr));
            if (cnt_clear) begin
                m_corr   = '0;
                m_uncorr = '0;
            end else if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                if (q[0].corr && m_corr != 16'hFFFF) m_corr = m_corr + 16'd1;
                if (q[0].uncorr && m_uncorr != 16'hFFFF) m_uncorr = m_uncorr + 16'd1;
            end
            if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                void'(q.pop_front());
                pops++;
            end
            if (bus.in_valid && bus.in_ready) begin
                ent_t e;
                e = model(bus.in_code);
                e.tag = cyc;
                q.push_back(e);
            end
        end
        cyc++;
    end

    task automatic send_one(input logic [16:0] code);
        logic rdy;
        int   n;
        bus.in_valid = 1'b1;
        bus.in_code  = code;
        n = 0;
        do begin
            #1;
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 50);
        bus.in_valid = 1'b0;
        if (!rdy) chk("send_timeout", 0, 1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [16:0] words [8];
    int          flips [8] = '{0, 3, 16, 0, 7, 17, 1, 0};

    initial begin
        ent_t m;
        int   idx;
        int   pops0;
        int   n;
        logic rdy;
        logic saw_block;

        resetn        = 1'b0;
        cnt_clear     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_code   = '0;
        bus.out_ready = 1'b0;

        // Pin the model against hand-decoded vectors.
        m = model(17'h00000);
        chk("pin0_data", 32'(m.data), 0);
        chk("pin0_syn", 32'(m.syn), 0);
        m = model(17'h00010);
        chk("pin1_syn", 32'(m.syn), 5);
        chk("pin1_corr", 32'(m.corr), 1);
        m = model(17'h1FFFF);
        chk("pin2_syn", 32'(m.syn), 1);
        chk("pin2_data", 32'(m.data), 32'hFFF);
        m = model(17'h08002);
        chk("pin3_syn", 32'(m.syn), 18);
        chk("pin3_uncorr", 32'(m.uncorr), 1);
        chk("pin3_corr", 32'(m.corr), 0);

        repeat (3) step();
        resetn = 1'b1;
        step();
        bus.out_ready = 1'b1;

        // Case 1: clean all-zero word
        send_one(17'h00000);
        step();
        chk("t1_valid", 32'(bus.out_valid), 1);
        chk("t1_data", 32'(bus.out_data), 0);
        chk("t1_syn", 32'(bus.out_syndrome), 0);
        chk("t1_flags", {30'd0, bus.out_corrected, bus.out_uncorr}, 0);
        step();
        chk("t1_cnt", 32'(cnt_corr), 0);

        // Case 2: position 5 flipped
        send_one(17'h00010);
        step();
        chk("t2_valid", 32'(bus.out_valid), 1);
        chk("t2_data", 32'(bus.out_data), 0);
        chk("t2_syn", 32'(bus.out_syndrome), 5);
        chk("t2_corr", 32'(bus.out_corrected), 1);
        step();
        chk("t2_cnt_corr", 32'(cnt_corr), 1);

        // Case 3: all ones, parity bit 1 wrong
        send_one(17'h1FFFF);
        step();
        chk("t3_syn", 32'(bus.out_syndrome), 1);
        chk("t3_data", 32'(bus.out_data), 32'hFFF);
        chk("t3_corr", 32'(bus.out_corrected), 1);
        step();
        chk("t3_cnt_corr", 32'(cnt_corr), 2);

        // Case 4: double error with syndrome 18
        send_one(17'h08002);
        step();
        chk("t4_syn", 32'(bus.out_syndrome), 18);
        chk("t4_uncorr", 32'(bus.out_uncorr), 1);
        chk("t4_corr", 32'(bus.out_corrected), 0);
        chk("t4_data", 32'(bus.out_data), 0);
        step();
        chk("t4_cnt_uncorr", 32'(cnt_uncorr), 1);

        // Clear on the same cycle a corrected beat is consumed
        bus.out_ready = 1'b0;
        send_one(17'h00010);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            step();
            n++;
        end
        chk("clr_wait_valid", 32'(bus.out_valid), 1);
        chk("clr_pre_cnt", 32'(cnt_corr), 2);
        bus.out_ready = 1'b1;
        cnt_clear     = 1'b1;
        step();
        cnt_clear = 1'b0;
        chk("clr_cnt_corr", 32'(cnt_corr), 0);
        chk("clr_cnt_uncorr", 32'(cnt_uncorr), 0);

        // Case 5: 8-word stream under toggling backpressure with a 3-cycle stall
        for (int i = 0; i < 8; i++) words[i] = enc(12'(i * 12'h135) ^ 12'hA5A, flips[i]);
        words[7] = words[7] ^ 17'h08002;
        idx       = 0;
        saw_block = 1'b0;
        pops0     = pops;
        for (int c = 0; c < 60 && idx < 8; c++) begin
            bus.out_ready = (c >= 3 && c < 6) ? 1'b0 : ((c % 2) == 0);
            bus.in_valid  = 1'b1;
            bus.in_code   = words[idx];
            #1;
            rdy = bus.in_ready;
            if (!rdy) saw_block = 1'b1;
            step();
            if (rdy) idx++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) step();
        chk("t5_all_sent", 32'(idx), 8);
        chk("t5_all_out", 32'(pops - pops0), 8);
        chk("t5_backpressure", 32'(saw_block), 1);
        chk("t5_drained", 32'(q.size()), 0);
        chk("t5_cnt_uncorr", 32'(cnt_uncorr), 1);

        // Case 6: async reset with two words held
        bus.out_ready = 1'b0;
        send_one(enc(12'h123, 5));
        send_one(enc(12'h456, 0));
        chk("t6_held_valid", 32'(bus.out_valid), 1);
        chk("t6_full", 32'(bus.in_ready), 0);
        chk("t6_pre_cnt", 32'(cnt_corr != 0), 1);
        resetn = 1'b0;
        #1;
        chk("t6_async_valid", 32'(bus.out_valid), 0);
        chk("t6_async_ready", 32'(bus.in_ready), 1);
        chk("t6_async_cnt_corr", 32'(cnt_corr), 0);
        chk("t6_async_cnt_uncorr", 32'(cnt_uncorr), 0);
        step();
        step();
        resetn = 1'b1;
        step();
        chk("t6_after_valid", 32'(bus.out_valid), 0);

        // Saturation: more than 2^16-1 corrected beats
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_code   = 17'h00010;
        repeat (65540) step();
        bus.in_valid = 1'b0;
        repeat (4) step();
        chk("sat_cnt_corr", 32'(cnt_corr), 32'hFFFF);
        chk("sat_cnt_uncorr", 32'(cnt_uncorr), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
